mem_dump_tx: RTL and testbench

//  Reads a block of 16-bit words from program/data memory and streams them out on uart_tx,

---
 rtl/comproc_pkg.sv | 25 ++
 rtl/uart_tx_byte.sv | 53 +++++
 rtl/mem_dump_tx.sv | 150 +++++++++++++++
 tb/tb_mem_dump_tx.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/comproc_pkg.sv
// Shared definitions for the memory dump transmitter and the UART program loader:
// dump FSM states, the baud divider helper and the end-of-block marker.
package comproc_pkg;

  typedef enum logic [3:0] {
    IDLE,
    REQ,
    WAIT,
    HI,
    LO,
    NEXT,
    END_HI,
    END_LO,
    FIN
  } dump_state_t;

  // Terminator word appended after a block; the loader stops on the same value.
  localparam logic [15:0] END_MARK_DEFAULT = 16'h7fff;

  // Clock cycles per serial bit, rounded to the nearest integer.
  function automatic int baud_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer. A byte accepted while ready is high starts its start bit
// on the next cycle; the line idles high and returns high at once on reset.
module uart_tx_byte #(
  parameter int DIV = 16
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST_TICK = CW'(DIV - 1);

  logic          active;
  logic [CW-1:0] bit_cnt;
  logic [3:0]    bit_idx;
  logic [9:0]    shift_q;

  // Load a frame on handshake, then shift one bit out every DIV cycles, filling with idle ones.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      active  <= 1'b0;
      bit_cnt <= '0;
      bit_idx <= '0;
      shift_q <= '1;
    end else if (!active) begin
      if (valid) begin
        shift_q <= {1'b1, data, 1'b0};
        active  <= 1'b1;
        bit_cnt <= '0;
        bit_idx <= '0;
      end
    end else if (bit_cnt == LAST_TICK) begin
      bit_cnt <= '0;
      shift_q <= {1'b1, shift_q[9:1]};
      if (bit_idx == 4'd9) begin
        active  <= 1'b0;
        bit_idx <= '0;
      end else begin
        bit_idx <= bit_idx + 4'd1;
      end
    end else begin
      bit_cnt <= bit_cnt + CW'(1);
    end
  end

  assign ready = !active;
  assign tx    = shift_q[0];

endmodule

// File: rtl/mem_dump_tx.sv
// Reads a block of 16-bit words over the mem bus and streams each word out on
// the UART, high byte first, optionally followed by the end marker word.
module mem_dump_tx
  import comproc_pkg::*;
#(
  parameter int          ADDR_WIDTH = 12,
  parameter int          CLK_HZ     = 27000000,
  parameter int          BAUD       = 115200,
  parameter logic [15:0] END_MARK   = END_MARK_DEFAULT,
  parameter bit          SEND_END   = 1'b1
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH-1:0] word_count,
  input  logic                  abort,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [15:0]           rd_data,
  output logic                  uart_tx,
  output logic                  busy,
  output logic                  done
);

  localparam int DIV = baud_div(CLK_HZ, BAUD);
  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] TWO = ADDR_WIDTH'(2);
  localparam dump_state_t AFTER_BLOCK = SEND_END ? END_HI : FIN;

  dump_state_t           state, next_state;
  logic [ADDR_WIDTH-1:0] addr_q, cnt_q;
  logic [15:0]           word_q;
  logic                  abort_q, abort_eff;
  logic                  done_q, done_set;
  logic                  ser_valid, ser_ready;
  logic [7:0]            ser_data;

  // A pending abort is honoured in every busy state; in IDLE it is simply dropped.
  assign abort_eff = abort | abort_q;

  // State register.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic and serializer hand-off; no byte is offered once an abort is pending.
  always_comb begin
    next_state = state;
    ser_valid  = 1'b0;
    ser_data   = word_q[15:8];
    done_set   = 1'b0;
    case (state)
      IDLE:   if (start) next_state = (word_count != '0) ? REQ : AFTER_BLOCK;
      REQ:    next_state = abort_eff ? FIN : WAIT;
      WAIT:   next_state = abort_eff ? FIN : HI;
      HI: begin
        if (abort_eff) next_state = FIN;
        else begin
          ser_valid = 1'b1;
          ser_data  = word_q[15:8];
          if (ser_ready) next_state = LO;
        end
      end
      LO: begin
        if (abort_eff) next_state = FIN;
        else begin
          ser_valid = 1'b1;
          ser_data  = word_q[7:0];
          if (ser_ready) next_state = NEXT;
        end
      end
      NEXT: begin
        if (abort_eff)           next_state = FIN;
        else if (cnt_q == ONE)   next_state = AFTER_BLOCK;
        else                     next_state = REQ;
      end
      END_HI: begin
        if (abort_eff) next_state = FIN;
        else begin
          ser_valid = 1'b1;
          ser_data  = END_MARK[15:8];
          if (ser_ready) next_state = END_LO;
        end
      end
      END_LO: begin
        if (abort_eff) next_state = FIN;
        else begin
          ser_valid = 1'b1;
          ser_data  = END_MARK[7:0];
          if (ser_ready) next_state = FIN;
        end
      end
      FIN: begin
        if (ser_ready) begin
          done_set   = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Address/count/word registers, sticky abort and the registered done pulse.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      abort_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= done_set;
      if (state == IDLE) abort_q <= 1'b0;
      else if (abort)    abort_q <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            addr_q <= start_addr & ~ONE;
            cnt_q  <= word_count;
          end
        end
        WAIT: word_q <= rd_data;
        NEXT: begin
          addr_q <= addr_q + TWO;
          cnt_q  <= cnt_q - ONE;
        end
        default: ;
      endcase
    end
  end

  assign mem_req  = (state == REQ);
  assign mem_addr = addr_q;
  assign busy     = (state != IDLE);
  assign done     = done_q;

  uart_tx_byte #(
    .DIV(DIV)
  ) u_ser (
    .sys_clk(sys_clk),
    .rst_n  (rst_n),
    .valid  (ser_valid),
    .data   (ser_data),
    .ready  (ser_ready),
    .tx     (uart_tx)
  );

endmodule

// File: tb/tb_mem_dump_tx.sv
// Bench for mem_dump_tx at CLK_HZ=16, BAUD=1 (16 cycles per bit) with a 1-cycle
// latency memory model, a line decoder and a list-based reference model.
module tb_mem_dump_tx;

  localparam int DIV = 16;

  logic        sys_clk = 1'b0;
  logic        rst_n   = 1'b0;
  logic        start = 1'b0, abort = 1'b0, start0 = 1'b0;
  logic [11:0] start_addr = '0, word_count = '0;
  logic        mem_req, uart_tx, busy, done;
  logic [11:0] mem_addr;
  logic [15:0] rd_data = '0;
  logic        mem_req0, uart_tx0, busy0, done0;
  logic [11:0] mem_addr0;
  logic [15:0] rd_data0 = '0;
  logic        abort0 = 1'b0;

  logic [15:0] mem [0:2047];

  int checks = 0, errors = 0;
  int cyc = 0, c0 = 0, rst_epoch = 0;
  int done_cnt = 0, done_t = 0, rx_starts = 0;
  logic [11:0] req_q[$], req0_q[$], exp_addr[$];
  logic [7:0]  rx_q[$], exp_bytes[$];
  int          rx_t_q[$];
  bit          rx_ok_q[$];

  mem_dump_tx #(.ADDR_WIDTH(12), .CLK_HZ(16), .BAUD(1), .END_MARK(16'h7fff), .SEND_END(1'b1)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .word_count(word_count), .abort(abort), .mem_req(mem_req), .mem_addr(mem_addr),
    .rd_data(rd_data), .uart_tx(uart_tx), .busy(busy), .done(done));

  mem_dump_tx #(.ADDR_WIDTH(12), .CLK_HZ(16), .BAUD(1), .END_MARK(16'h7fff), .SEND_END(1'b0)) dut0 (
    .sys_clk(sys_clk), .rst_n(rst_n), .start(start0), .start_addr(start_addr),
    .word_count(word_count), .abort(abort0), .mem_req(mem_req0), .mem_addr(mem_addr0),
    .rd_data(rd_data0), .uart_tx(uart_tx0), .busy(busy0), .done(done0));

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Memory answers one cycle after mem_req; otherwise the bus carries noise.
  always @(posedge sys_clk) begin
    rd_data  <= mem_req ? mem[mem_addr[11:1]] : 16'($urandom);
    rd_data0 <= mem[mem_addr0[11:1]];
  end

  always @(negedge rst_n) rst_epoch++;

  // Bus and completion monitors.
  always @(negedge sys_clk) begin
    if (mem_req === 1'b1) req_q.push_back(mem_addr);
    if (mem_req0 === 1'b1) req0_q.push_back(mem_addr0);
    if (done === 1'b1) begin
      done_cnt++;
      done_t = cyc;
    end
  end

  // Line decoder: samples mid-bit, discards frames cut by a reset.
  int          dec_ep, dec_t0;
  logic [7:0]  dec_b;
  bit          dec_ok;
  initial begin
    forever begin
      @(negedge sys_clk);
      if (rst_n === 1'b1 && uart_tx === 1'b0) begin
        dec_ep = rst_epoch;
        dec_t0 = cyc;
        dec_ok = 1'b1;
        rx_starts++;
        repeat (DIV / 2) @(negedge sys_clk);
        if (uart_tx !== 1'b0) dec_ok = 1'b0;
        for (int k = 0; k < 8; k++) begin
          repeat (DIV) @(negedge sys_clk);
          dec_b[k] = uart_tx;
        end
        repeat (DIV) @(negedge sys_clk);
        if (uart_tx !== 1'b1) dec_ok = 1'b0;
        if (dec_ep == rst_epoch) begin
          rx_q.push_back(dec_b);
          rx_t_q.push_back(dec_t0);
          rx_ok_q.push_back(dec_ok);
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [11:0] sa, input logic [11:0] cnt, input bit with_abort);
    @(negedge sys_clk);
    req_q.delete(); rx_q.delete(); rx_t_q.delete(); rx_ok_q.delete();
    done_cnt = 0; rx_starts = 0;
    start_addr = sa; word_count = cnt; start = 1'b1; abort = with_abort; c0 = cyc;
    @(negedge sys_clk);
    start = 1'b0; abort = 1'b0;
    start_addr = 12'($urandom); word_count = 12'($urandom);
    checkOutput("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic waitDone(input int budget);
    int k;
    k = 0;
    while (done_cnt == 0 && k < budget) begin
      @(negedge sys_clk);
      k++;
    end
    checkOutput("done_timeout", 32'(done_cnt == 0), 32'd0);
    repeat (3) @(negedge sys_clk);
  endtask

  // Expected addresses and line bytes from the block description alone.
  task automatic buildModel(input logic [11:0] sa, input int n_req, input int n_words, input bit with_end);
    logic [11:0] a;
    logic [15:0] w;
    exp_addr.delete(); exp_bytes.delete();
    for (int i = 0; i < n_req; i++) begin
      a = (sa & 12'hffe) + 12'(2 * i);
      exp_addr.push_back(a);
    end
    for (int i = 0; i < n_words; i++) begin
      a = (sa & 12'hffe) + 12'(2 * i);
      w = mem[a[11:1]];
      exp_bytes.push_back(w[15:8]);
      exp_bytes.push_back(w[7:0]);
    end
    if (with_end) begin
      exp_bytes.push_back(8'h7f);
      exp_bytes.push_back(8'hff);
    end
  endtask

  task automatic checkTransaction(input bit timed);
    int n;
    checkOutput("done_pulses", 32'(done_cnt), 32'd1);
    checkOutput("busy_idle", 32'(busy), 32'd0);
    checkOutput("req_count", 32'(req_q.size()), 32'(exp_addr.size()));
    for (int i = 0; i < req_q.size() && i < exp_addr.size(); i++)
      checkOutput("req_addr", 32'(req_q[i]), 32'(exp_addr[i]));
    checkOutput("byte_count", 32'(rx_q.size()), 32'(exp_bytes.size()));
    for (int i = 0; i < rx_q.size() && i < exp_bytes.size(); i++) begin
      checkOutput("rx_byte", 32'(rx_q[i]), 32'(exp_bytes[i]));
      checkOutput("stop_bit", 32'(rx_ok_q[i]), 32'd1);
    end
    for (int i = 1; i < rx_t_q.size(); i++)
      checkOutput("frame_gap", 32'((rx_t_q[i] - rx_t_q[i-1]) inside {160, 161}), 32'd1);
    n = rx_t_q.size();
    if (n > 0) begin
      checkOutput("done_delay", 32'((done_t - rx_t_q[n-1]) inside {160, 161}), 32'd1);
      if (timed) begin
        checkOutput("first_bit_latency", 32'(rx_t_q[0] - c0), 32'd4);
        checkOutput("total_time", 32'((done_t - c0) <= n * 162), 32'd1);
      end
    end
  endtask

  int          wait_k, low_len, high_len, d0_at;
  bit          tx0_low;
  logic [11:0] rsa, rcnt;

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 16'($urandom);
    repeat (3) @(negedge sys_clk);
    checkOutput("rst_uart_tx", 32'(uart_tx), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    $display("[TB] single word with end marker");
    mem[12'h300 >> 1] = 16'h1234;
    applyStimulus(12'h300, 12'd1, 1'b0);
    waitDone(1500);
    buildModel(12'h300, 1, 1, 1'b1);
    checkTransaction(1'b1);

    $display("[TB] odd start address, three words");
    mem[12'h300 >> 1] = 16'hA1B2; mem[12'h302 >> 1] = 16'hC3D4; mem[12'h304 >> 1] = 16'hE5F6;
    applyStimulus(12'h301, 12'd3, 1'b0);
    waitDone(2500);
    buildModel(12'h301, 3, 3, 1'b1);
    checkTransaction(1'b1);

    $display("[TB] zero words, end marker only");
    applyStimulus(12'h456, 12'd0, 1'b0);
    waitDone(1000);
    buildModel(12'h456, 0, 0, 1'b1);
    checkTransaction(1'b0);

    $display("[TB] zero words without end marker");
    req0_q.delete();
    d0_at = -1; tx0_low = 1'b0;
    @(negedge sys_clk);
    start_addr = 12'h123; word_count = 12'd0; start0 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge sys_clk);
      if (k == 1) begin
        start0 = 1'b0;
        checkOutput("end0_busy", 32'(busy0), 32'd1);
      end
      if (done0 === 1'b1 && d0_at < 0) d0_at = k;
      if (uart_tx0 !== 1'b1) tx0_low = 1'b1;
    end
    checkOutput("end0_done_cycle", 32'(d0_at), 32'd2);
    checkOutput("end0_line_idle", 32'(tx0_low), 32'd0);
    checkOutput("end0_no_req", 32'(req0_q.size()), 32'd0);
    checkOutput("end0_busy_idle", 32'(busy0), 32'd0);

    $display("[TB] address wrap");
    applyStimulus(12'hFFE, 12'd2, 1'b0);
    waitDone(2000);
    buildModel(12'hFFE, 2, 2, 1'b1);
    checkTransaction(1'b1);

    $display("[TB] random blocks");
    for (int r = 0; r < 3; r++) begin
      rsa  = 12'($urandom);
      rcnt = 12'($urandom_range(1, 3));
      applyStimulus(rsa, rcnt, r == 0);
      waitDone(2000);
      buildModel(rsa, int'(rcnt), int'(rcnt), 1'b1);
      checkTransaction(1'b1);
    end

    $display("[TB] abort during second frame");
    rsa = 12'($urandom);
    applyStimulus(rsa, 12'd4, 1'b0);
    wait_k = 0;
    while (rx_starts < 2 && wait_k < 600) begin
      @(negedge sys_clk);
      wait_k++;
    end
    checkOutput("abort_frame_timeout", 32'(rx_starts < 2), 32'd0);
    repeat (20) @(negedge sys_clk);
    abort = 1'b1;
    @(negedge sys_clk);
    abort = 1'b0;
    repeat (20) @(negedge sys_clk);
    start = 1'b1; start_addr = 12'h000; word_count = 12'd5;
    @(negedge sys_clk);
    start = 1'b0;
    waitDone(1000);
    repeat (200) @(negedge sys_clk);
    buildModel(rsa, 2, 1, 1'b0);
    checkTransaction(1'b0);

    $display("[TB] reset mid-frame");
    applyStimulus(12'h200, 12'd1, 1'b0);
    wait_k = 0;
    while (rx_starts < 1 && wait_k < 100) begin
      @(negedge sys_clk);
      wait_k++;
    end
    repeat (50) @(negedge sys_clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_uart_tx", 32'(uart_tx), 32'd1);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_mem_req", 32'(mem_req), 32'd0);
    repeat (2) @(negedge sys_clk);
    rst_n = 1'b1;
    repeat (170) @(negedge sys_clk);
    mem[12'h100 >> 1] = 16'h55C3;
    applyStimulus(12'h100, 12'd1, 1'b0);
    wait_k = 0;
    while (uart_tx !== 1'b0 && wait_k < 20) begin
      @(negedge sys_clk);
      wait_k++;
    end
    low_len = 0;
    while (uart_tx === 1'b0 && low_len < 40) begin
      low_len++;
      @(negedge sys_clk);
    end
    high_len = 0;
    while (uart_tx === 1'b1 && high_len < 40) begin
      high_len++;
      @(negedge sys_clk);
    end
    checkOutput("post_rst_start_bit_len", 32'(low_len), 32'd16);
    checkOutput("post_rst_d0_len", 32'(high_len), 32'd16);
    waitDone(1500);
    buildModel(12'h100, 1, 1, 1'b1);
    checkTransaction(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
